regfile_2r1w: RTL and testbench

- Parametrised successor to the team's 16x16 register file: NUM_REGS x DATA_W storage with one byte-masked write port and two independent registered read ports.
- Adds per-port read valids, out-of-range address handling, and a software-triggered sequential clear with a busy flag.
- Sits between the datapath write-back stage and the ALU operand latches; the controller drives the enables and addresses.

---
 rtl/regfile_2r1w.sv | 186 ++++++++++++++++++
 tb/tb_regfile_2r1w.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// ============================================================================
//  Module   : regfile_2r1w
//  Purpose  : NUM_REGS x DATA_W register file, one byte-masked write port,
//             two registered read ports, sequential software clear with busy.
//             Define REGFILE_BYPASS_EN to forward same-edge writes to reads.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_2r1w #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic [DATA_W/8-1:0]   i_wr_be,
    input  logic                  i_rd_a_en,
    input  logic [ADDR_W-1:0]     i_rd_a_addr,
    output logic [DATA_W-1:0]     o_rd_a_data,
    output logic                  o_rd_a_valid,
    input  logic                  i_rd_b_en,
    input  logic [ADDR_W-1:0]     i_rd_b_addr,
    output logic [DATA_W-1:0]     o_rd_b_data,
    output logic                  o_rd_b_valid,
    input  logic                  i_clr,
    output logic                  o_busy
);

    localparam int                c_NB       = DATA_W / 8;
    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]    w_cnt_nxt;
    logic                 r_busy;

    logic [DATA_W-1:0]    r_mem [NUM_REGS];

    logic [DATA_W-1:0]    r_rd_a_data;
    logic [DATA_W-1:0]    r_rd_b_data;
    logic                 r_rd_a_valid;
    logic                 r_rd_b_valid;

    logic                 w_active;
    logic                 w_wr_ok;
    logic                 w_rd_a_go;
    logic                 w_rd_b_go;
    logic [DATA_W-1:0]    w_wr_old;
    logic [DATA_W-1:0]    w_wr_merged;
    logic [DATA_W-1:0]    w_rd_a_raw;
    logic [DATA_W-1:0]    w_rd_b_raw;
    logic [DATA_W-1:0]    w_rd_a_val;
    logic [DATA_W-1:0]    w_rd_b_val;

    function automatic logic [DATA_W-1:0] f_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [c_NB-1:0]   be
    );
        logic [DATA_W-1:0] m;
        m = old_word;
        for (int k = 0; k < c_NB; k++) begin
            if (be[k]) begin
                m[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return m;
    endfunction

    assign w_active  = i_en & ~r_busy;
    assign w_wr_ok   = w_active & i_wr_en & (int'(i_wr_addr) < NUM_REGS);
    assign w_rd_a_go = w_active & i_rd_a_en;
    assign w_rd_b_go = w_active & i_rd_b_en;

    // Unimplemented addresses match no entry and therefore read as zero.
    always_comb begin
        w_rd_a_raw = '0;
        w_rd_b_raw = '0;
        w_wr_old   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_rd_a_addr == ADDR_W'(i)) w_rd_a_raw = r_mem[i];
            if (i_rd_b_addr == ADDR_W'(i)) w_rd_b_raw = r_mem[i];
            if (i_wr_addr   == ADDR_W'(i)) w_wr_old   = r_mem[i];
        end
    end

    assign w_wr_merged = f_merge(w_wr_old, i_wr_data, i_wr_be);

`ifdef REGFILE_BYPASS_EN
    assign w_rd_a_val = (w_wr_ok && (i_wr_addr == i_rd_a_addr)) ? w_wr_merged : w_rd_a_raw;
    assign w_rd_b_val = (w_wr_ok && (i_wr_addr == i_rd_b_addr)) ? w_wr_merged : w_rd_b_raw;
`else
    assign w_rd_a_val = w_rd_a_raw;
    assign w_rd_b_val = w_rd_b_raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (r_busy && (r_cnt == ADDR_W'(i))) begin
                    r_mem[i] <= '0;
                end else if (w_wr_ok && (i_wr_addr == ADDR_W'(i))) begin
                    r_mem[i] <= w_wr_merged;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_a_data  <= '0;
            r_rd_b_data  <= '0;
            r_rd_a_valid <= 1'b0;
            r_rd_b_valid <= 1'b0;
        end else begin
            r_rd_a_valid <= w_rd_a_go;
            r_rd_b_valid <= w_rd_b_go;
            if (w_rd_a_go) r_rd_a_data <= w_rd_a_val;
            if (w_rd_b_go) r_rd_b_data <= w_rd_b_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt == S_CLEAR);
        end
    end

    // en=0 leaves next-state equal to current state, which pauses the clear.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_en && i_clr) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                if (i_en) begin
                    if (r_cnt == c_LAST_IDX) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_rd_a_data  = r_rd_a_data;
    assign o_rd_b_data  = r_rd_b_data;
    assign o_rd_a_valid = r_rd_a_valid;
    assign o_rd_b_valid = r_rd_b_valid;
    assign o_busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
// ============================================================================
//  Module   : tb_regfile_2r1w
//  Purpose  : directed scoreboard bench for regfile_2r1w (16x16 and 12x16).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, wr_en, rda_en, rdb_en, clr;
    logic [3:0]  wr_addr, rda_addr, rdb_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic [15:0] rda_data, rdb_data;
    logic        rda_valid, rdb_valid, busy;

    logic        t_wr_en, t_rda_en;
    logic [3:0]  t_wr_addr, t_rda_addr;
    logic [15:0] t_wr_data;
    logic [15:0] t_rda_data, t_rdb_data;
    logic        t_rda_valid, t_rdb_valid, t_busy;

    always #5 clk = ~clk;

    regfile_2r1w #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(16)) dut (
        .clk(clk), .rst(rst), .i_en(en),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_be(wr_be),
        .i_rd_a_en(rda_en), .i_rd_a_addr(rda_addr), .o_rd_a_data(rda_data), .o_rd_a_valid(rda_valid),
        .i_rd_b_en(rdb_en), .i_rd_b_addr(rdb_addr), .o_rd_b_data(rdb_data), .o_rd_b_valid(rdb_valid),
        .i_clr(clr), .o_busy(busy)
    );

    regfile_2r1w #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(12)) dut12 (
        .clk(clk), .rst(rst), .i_en(1'b1),
        .i_wr_en(t_wr_en), .i_wr_addr(t_wr_addr), .i_wr_data(t_wr_data), .i_wr_be(2'b11),
        .i_rd_a_en(t_rda_en), .i_rd_a_addr(t_rda_addr), .o_rd_a_data(t_rda_data), .o_rd_a_valid(t_rda_valid),
        .i_rd_b_en(1'b0), .i_rd_b_addr(4'd0), .o_rd_b_data(t_rdb_data), .o_rd_b_valid(t_rdb_valid),
        .i_clr(1'b0), .o_busy(t_busy)
    );

    logic [15:0] mdl [16];
    bit          m_busy;
    int          m_idx;
    logic [15:0] qa [$];
    logic [15:0] qb [$];
    int          n_cmp = 0;
    int          n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic idle();
        en = 1'b1; wr_en = 1'b0; rda_en = 1'b0; rdb_en = 1'b0; clr = 1'b0;
        wr_addr = '0; wr_data = '0; wr_be = 2'b11; rda_addr = '0; rdb_addr = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        m_busy = 1'b0;
        m_idx  = 0;
        qa.delete();
        qb.delete();
    endtask

    // Predict the edge from the current inputs, advance one cycle, compare.
    task automatic step();
        bit          pa, pb, wok;
        logic [15:0] ea, eb, wv;
        pa  = en && rda_en && !m_busy;
        pb  = en && rdb_en && !m_busy;
        wok = en && wr_en && !m_busy;
        wv  = mdl[wr_addr];
        for (int k = 0; k < 2; k++) if (wr_be[k]) wv[8*k +: 8] = wr_data[8*k +: 8];
        ea = mdl[rda_addr];
        eb = mdl[rdb_addr];
`ifdef REGFILE_BYPASS_EN
        if (wok && wr_addr == rda_addr) ea = wv;
        if (wok && wr_addr == rdb_addr) eb = wv;
`endif
        if (pa) qa.push_back(ea);
        if (pb) qb.push_back(eb);
        if (wok) mdl[wr_addr] = wv;
        if (en && m_busy) begin
            mdl[m_idx] = '0;
            m_idx++;
            if (m_idx == 16) begin
                m_busy = 1'b0;
                m_idx  = 0;
            end
        end else if (en && clr) begin
            m_busy = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("busy", busy, m_busy);
        chk("valid_a", rda_valid, pa);
        chk("valid_b", rdb_valid, pb);
        if (pa) chk("data_a", rda_data, qa.pop_front());
        if (pb) chk("data_b", rdb_data, qb.pop_front());
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        idle(); wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        step();
    endtask

    task automatic rd2(input logic [3:0] a, input logic [3:0] b);
        idle(); rda_en = 1'b1; rda_addr = a; rdb_en = 1'b1; rdb_addr = b;
        step();
    endtask

    task automatic t12(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic re, input logic [3:0] ra);
        t_wr_en = we; t_wr_addr = wa; t_wr_data = wd; t_rda_en = re; t_rda_addr = ra;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nb;
        rst = 1'b1;
        idle();
        t_wr_en = 1'b0; t_wr_addr = '0; t_wr_data = '0; t_rda_en = 1'b0; t_rda_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_a", rda_valid, 1'b0);
        chk("rst_valid_b", rdb_valid, 1'b0);
        chk("rst_data_a", rda_data, 16'h0000);
        chk("rst_data_b", rdb_data, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        idle();
        step();

        rd2(4'd3, 4'd15);

        wr(4'd5, 16'hABCD, 2'b11);
        wr(4'd5, 16'h1234, 2'b01);
        rd2(4'd5, 4'd5);
        idle();
        step();

        wr(4'd7, 16'h1111, 2'b11);
        idle(); wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h2222; rda_en = 1'b1; rda_addr = 4'd7;
        step();
        idle(); rdb_en = 1'b1; rdb_addr = 4'd7;
        step();

        for (int i = 0; i < 16; i++) wr(4'(i), 16'hFFFF, 2'b11);
        idle(); clr = 1'b1;
        step();
        nb = busy ? 1 : 0;
        for (int j = 0; j < 40 && busy; j++) begin
            idle();
            if (j == 3) begin
                wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h5555; rda_en = 1'b1; rda_addr = 4'd2;
            end
            if (j == 4) clr = 1'b1;
            step();
            if (busy) nb++;
        end
        chk("clr_len", nb, 16);
        for (int i = 0; i < 16; i++) rd2(4'(i), 4'(15 - i));

        for (int i = 0; i < 16; i++) wr(4'(i), 16'hFFFF, 2'b11);
        idle(); clr = 1'b1;
        step();
        nb = busy ? 1 : 0;
        for (int j = 0; j < 40 && busy; j++) begin
            idle();
            if (j >= 5 && j <= 7) begin
                en = 1'b0; rda_en = 1'b1; rda_addr = 4'd1;
            end
            step();
            if (busy) nb++;
        end
        chk("clr_len_paused", nb, 19);
        for (int i = 0; i < 16; i++) rd2(4'(i), 4'(15 - i));

        for (int i = 0; i < 16; i++) wr(4'(i), 16'h0101 * 16'(i + 1), 2'b11);
        idle(); clr = 1'b1;
        step();
        idle();
        repeat (5) step();
        #3 rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_valid_a", rda_valid, 1'b0);
        model_reset();
        #2 rst = 1'b0;
        idle();
        step();
        for (int i = 0; i < 16; i++) rd2(4'(i), 4'(15 - i));

        for (int i = 0; i < 12; i++) t12(1'b1, 4'(i), 16'hA000 + 16'(i), 1'b0, 4'd0);
        t12(1'b1, 4'd13, 16'hBEEF, 1'b0, 4'd0);
        t12(1'b0, 4'd0, 16'h0000, 1'b1, 4'd13);
        chk("oor_valid", t_rda_valid, 1'b1);
        chk("oor_data", t_rda_data, 16'h0000);
        for (int i = 0; i < 12; i++) begin
            t12(1'b0, 4'd0, 16'h0000, 1'b1, 4'(i));
            chk("oor_keep", t_rda_data, 16'hA000 + 16'(i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
